// File: rtl/cms_pkg.sv
// Shared definitions for the CMS control sequencer.
//  - cms_state_e : sequencer FSM state encoding
//  - cms_cmd_t   : command record {last, addr, data} at the default widths
//  - cmd_width() : packed command width for any address/data width
package cms_pkg;

   localparam int CMS_ADDR_WIDTH = 8;
   localparam int CMS_DATA_WIDTH = 64;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_QUIESCE,
      ST_WRITE,
      ST_GAP,
      ST_RESUME
   } cms_state_e;

   typedef struct packed {
      logic                      last;
      logic [CMS_ADDR_WIDTH-1:0] addr;
      logic [CMS_DATA_WIDTH-1:0] data;
   } cms_cmd_t;

   // The FIFO stores commands packed as {last, addr, data}, so one extra bit
   // is needed on top of the address and data fields.
   function automatic int cmd_width(input int aw, input int dw);
      return aw + dw + 1;
   endfunction

endpackage

// File: rtl/cms_cmd_fifo.sv
// Synchronous command FIFO with a registered head word.
// Ports:
//  clk, rst  clock, asynchronous active-high reset
//  push      write wdata (ignored while full)
//  wdata     word to write
//  pop       drop the current head (ignored while empty)
//  head      registered oldest entry, valid while !empty
//  full      occupancy == DEPTH
//  empty     occupancy == 0
//  level     occupancy, 0..DEPTH
module cms_cmd_fifo #(
   parameter int WIDTH = 73,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_next;
   logic             do_push;
   logic             do_pop;

   assign full    = (level == LW'(DEPTH));
   assign empty   = (level == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_next = rd_ptr + AW'(do_pop);

   // Storage array; no reset needed because level/head gate every read.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointers, occupancy and the head register. When the FIFO is (or becomes)
   // empty apart from the incoming word, that word goes straight into the head;
   // otherwise the head is refilled from the entry behind the popped one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
         head   <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         rd_ptr <= rd_next;
         case ({do_push, do_pop})
            2'b10:   level <= level + LW'(1);
            2'b01:   level <= level - LW'(1);
            default: level <= level;
         endcase
         if (do_push && (level == LW'(do_pop))) begin
            head <= wdata;
         end else if (do_push || do_pop) begin
            head <= mem[rd_next];
         end
      end
   end

endmodule

// File: rtl/cms_ctrl_sequencer.sv
// Host-side configuration sequencer for the continuous monitoring system.
// Buffers host (addr, data, last) commands and replays each batch onto the
// CMS control port as single-cycle write-enable pulses separated by a low
// cycle, optionally pausing monitoring (cms_en low) around the batch.
// Ports:
//  clk, rst            clock, asynchronous active-high reset
//  s_cmd_*             host command stream (valid/ready, addr, data, last)
//  host_en             requested monitoring enable, sampled in IDLE only
//  ctrl_addr/ctrl_wdata/ctrl_write_enable  CMS control port
//  cms_en              CMS monitoring enable
//  busy                sequencer not idle
//  batch_done          one-cycle pulse at the end of each batch
//  cmd_level           command FIFO occupancy
module cms_ctrl_sequencer #(
   parameter int ADDR_WIDTH     = 8,
   parameter int DATA_WIDTH     = 64,
   parameter int FIFO_DEPTH     = 8,
   parameter int PAUSE_MONITOR  = 1,
   parameter int QUIESCE_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_cmd_valid,
   output logic                          s_cmd_ready,
   input  logic [ADDR_WIDTH-1:0]         s_cmd_addr,
   input  logic [DATA_WIDTH-1:0]         s_cmd_data,
   input  logic                          s_cmd_last,
   input  logic                          host_en,
   output logic [ADDR_WIDTH-1:0]         ctrl_addr,
   output logic [DATA_WIDTH-1:0]         ctrl_wdata,
   output logic                          ctrl_write_enable,
   output logic                          cms_en,
   output logic                          busy,
   output logic                          batch_done,
   output logic [$clog2(FIFO_DEPTH):0]   cmd_level
);

   import cms_pkg::*;

   localparam int CW = cmd_width(ADDR_WIDTH, DATA_WIDTH);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int QW = $clog2(QUIESCE_CYCLES + 1);

   cms_state_e             state;
   cms_state_e             next_state;
   logic [QW-1:0]          q_cnt;
   logic                   last_flag;
   logic [LW-1:0]          batch_pending;
   logic [CW-1:0]          fifo_head;
   logic                   fifo_full;
   logic                   fifo_empty;
   logic                   push;
   logic                   pop;
   logic                   head_last;
   logic [ADDR_WIDTH-1:0]  head_addr;
   logic [DATA_WIDTH-1:0]  head_data;

   assign s_cmd_ready = !fifo_full && !rst;
   assign push        = s_cmd_valid && s_cmd_ready;
   assign pop         = (state == ST_WRITE);
   assign busy        = (state != ST_IDLE);
   assign head_last   = fifo_head[CW-1];
   assign head_addr   = fifo_head[CW-2 -: ADDR_WIDTH];
   assign head_data   = fifo_head[DATA_WIDTH-1:0];

   cms_cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .wdata ({s_cmd_last, s_cmd_addr, s_cmd_data}),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (cmd_level)
   );

   // Number of complete batches sitting in the FIFO. A batch that is bigger
   // than the FIFO never gets counted until its last word arrives, which is
   // why a full FIFO also starts the sequence.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         batch_pending <= '0;
      end else begin
         case ({push && s_cmd_last, pop && head_last})
            2'b10:   batch_pending <= batch_pending + LW'(1);
            2'b01:   batch_pending <= batch_pending - LW'(1);
            default: batch_pending <= batch_pending;
         endcase
      end
   end

   // Next-state logic. WRITE always falls into GAP so consecutive pulses are
   // separated by a low cycle; GAP parks when a long batch drains the FIFO.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE: begin
            if ((batch_pending != '0) || fifo_full) begin
               next_state = (PAUSE_MONITOR != 0) ? ST_QUIESCE : ST_WRITE;
            end
         end
         ST_QUIESCE: begin
            if (q_cnt == QW'(QUIESCE_CYCLES - 1)) begin
               next_state = ST_WRITE;
            end
         end
         ST_WRITE: next_state = ST_GAP;
         ST_GAP: begin
            if (last_flag) begin
               next_state = ST_RESUME;
            end else if (!fifo_empty) begin
               next_state = ST_WRITE;
            end
         end
         ST_RESUME: next_state = ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   // State register plus Moore outputs decoded from next_state, so every
   // output changes on the same edge as the state it belongs to. The head
   // word is captured on entry to WRITE and popped during the WRITE cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_IDLE;
         q_cnt             <= '0;
         last_flag         <= 1'b0;
         ctrl_addr         <= '0;
         ctrl_wdata        <= '0;
         ctrl_write_enable <= 1'b0;
         cms_en            <= 1'b0;
         batch_done        <= 1'b0;
      end else begin
         state             <= next_state;
         ctrl_write_enable <= (next_state == ST_WRITE);
         batch_done        <= (next_state == ST_RESUME);
         if (state == ST_QUIESCE) begin
            q_cnt <= q_cnt + QW'(1);
         end else begin
            q_cnt <= '0;
         end
         if (next_state == ST_WRITE) begin
            ctrl_addr  <= head_addr;
            ctrl_wdata <= head_data;
            last_flag  <= head_last;
         end
         if (next_state == ST_IDLE) begin
            cms_en <= host_en;
         end else if ((next_state == ST_QUIESCE) || (PAUSE_MONITOR != 0)) begin
            cms_en <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_cms_ctrl_sequencer.sv
// Self-checking bench for cms_ctrl_sequencer. Two instances share the input
// stimulus: dut_a pauses monitoring (PAUSE_MONITOR=1), dut_b does not.
// Cycle-accurate expectations live in a vector table; the long-batch and
// mid-operation reset cases are hand-written sequences.
module tb_cms_ctrl_sequencer;

   logic        clk;
   logic        rst;
   logic        s_cmd_valid;
   logic [7:0]  s_cmd_addr;
   logic [63:0] s_cmd_data;
   logic        s_cmd_last;
   logic        host_en;

   logic        ready_a, we_a, en_a, busy_a, done_a;
   logic [7:0]  addr_a;
   logic [63:0] wdata_a;
   logic [3:0]  level_a;
   logic        ready_b, we_b, en_b, busy_b, done_b;
   logic [7:0]  addr_b;
   logic [63:0] wdata_b;
   logic [3:0]  level_b;

   int n_compared;
   int n_mismatched;

   typedef struct {
      int          tst;
      int          cyc;
      logic        hen;
      logic        we;
      logic [7:0]  addr;
      logic [63:0] data;
      logic        en;
      logic        done;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] wr_log[$];
   logic       prev_we;

   cms_ctrl_sequencer #(
      .ADDR_WIDTH(8), .DATA_WIDTH(64), .FIFO_DEPTH(8),
      .PAUSE_MONITOR(1), .QUIESCE_CYCLES(4)
   ) dut_a (
      .clk(clk), .rst(rst),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(ready_a),
      .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_last(s_cmd_last),
      .host_en(host_en),
      .ctrl_addr(addr_a), .ctrl_wdata(wdata_a), .ctrl_write_enable(we_a),
      .cms_en(en_a), .busy(busy_a), .batch_done(done_a), .cmd_level(level_a)
   );

   cms_ctrl_sequencer #(
      .ADDR_WIDTH(8), .DATA_WIDTH(64), .FIFO_DEPTH(8),
      .PAUSE_MONITOR(0), .QUIESCE_CYCLES(4)
   ) dut_b (
      .clk(clk), .rst(rst),
      .s_cmd_valid(s_cmd_valid), .s_cmd_ready(ready_b),
      .s_cmd_addr(s_cmd_addr), .s_cmd_data(s_cmd_data), .s_cmd_last(s_cmd_last),
      .host_en(host_en),
      .ctrl_addr(addr_b), .ctrl_wdata(wdata_b), .ctrl_write_enable(we_b),
      .cms_en(en_b), .busy(busy_b), .batch_done(done_b), .cmd_level(level_b)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case some bounded wait was overlooked.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
      $fatal(1, "[TB] watchdog");
   end

   // Logs every write pulse of dut_a and checks that it was preceded by a
   // low cycle, as a posedge-triggered sink requires.
   always @(negedge clk) begin
      if (rst) begin
         prev_we = 1'b0;
      end else begin
         if (we_a) begin
            wr_log.push_back(addr_a);
            checkOutput("we_low_gap", 64'(prev_we), 64'(0));
         end
         prev_we = we_a;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_compared++;
      if (actual !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic failTimeout(input string name);
      n_compared++;
      n_mismatched++;
      $display("[TB] FAIL %s: wait expired, got timeout, expected event", name);
   endtask

   // Offers one command and holds it until dut_a accepts it; returns just
   // after the accepting edge (cycle 0).
   task automatic applyStimulus(input logic [7:0] addr, input logic [63:0] data, input logic last);
      int k;
      s_cmd_valid = 1'b1;
      s_cmd_addr  = addr;
      s_cmd_data  = data;
      s_cmd_last  = last;
      k = 0;
      while (!ready_a && k < 200) begin
         tick();
         k++;
      end
      if (!ready_a) failTimeout("push_ready");
      tick();
      s_cmd_valid = 1'b0;
      s_cmd_last  = 1'b0;
   endtask

   task automatic doReset();
      s_cmd_valid = 1'b0;
      s_cmd_last  = 1'b0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      wr_log.delete();
      tick();
      tick();
   endtask

   task automatic addVec(input int tst, input int cyc, input logic hen, input logic we,
                         input logic [7:0] addr, input logic [63:0] data, input logic en, input logic done);
      vec_t v;
      v.tst = tst; v.cyc = cyc; v.hen = hen; v.we = we;
      v.addr = addr; v.data = data; v.en = en; v.done = done;
      vecs.push_back(v);
   endtask

   // Plays the vectors of one test, one edge per vector, starting in cycle 0.
   task automatic runTable(input int tst, input bit use_b);
      logic        we, en, done;
      logic [7:0]  addr;
      logic [63:0] data;
      foreach (vecs[i]) begin
         if (vecs[i].tst == tst) begin
            host_en = vecs[i].hen;
            tick();
            we   = use_b ? we_b    : we_a;
            en   = use_b ? en_b    : en_a;
            done = use_b ? done_b  : done_a;
            addr = use_b ? addr_b  : addr_a;
            data = use_b ? wdata_b : wdata_a;
            checkOutput($sformatf("t%0d_c%0d_we", tst, vecs[i].cyc), 64'(we), 64'(vecs[i].we));
            checkOutput($sformatf("t%0d_c%0d_en", tst, vecs[i].cyc), 64'(en), 64'(vecs[i].en));
            checkOutput($sformatf("t%0d_c%0d_done", tst, vecs[i].cyc), 64'(done), 64'(vecs[i].done));
            if (vecs[i].we) begin
               checkOutput($sformatf("t%0d_c%0d_addr", tst, vecs[i].cyc), 64'(addr), 64'(vecs[i].addr));
               checkOutput($sformatf("t%0d_c%0d_data", tst, vecs[i].cyc), data, vecs[i].data);
            end
         end
      end
   endtask

   initial begin
      int k;
      logic [7:0] a2;
      n_compared   = 0;
      n_mismatched = 0;
      prev_we      = 1'b0;

      // Expected per-cycle behaviour, cycle n = after edge En, E0 = last push.
      // 1: single entry, Q=4: pulse in 5, done in 7, enable back in 8.
      for (int c = 1; c <= 9; c++)
         addVec(1, c, 1'b1, c == 5, 8'h03, 64'h1, c >= 8, c == 7);
      // 2: three entries 10/11/12: pulses 5/7/9, done 11, enable back 12.
      for (int c = 1; c <= 12; c++) begin
         a2 = 8'h10 + 8'((c - 5) / 2);
         addVec(2, c, 1'b1, (c == 5) || (c == 7) || (c == 9), a2,
                64'hC0DE_0000_0000_0000 | 64'(a2), c >= 12, c == 11);
      end
      // 4: no pause: pulse in 1, done in 3, enable never drops.
      for (int c = 1; c <= 4; c++)
         addVec(4, c, 1'b1, c == 1, 8'h03, 64'h1, 1'b1, c == 3);
      // 6: host_en drops during QUIESCE: enable stays low after RESUME.
      for (int c = 1; c <= 9; c++)
         addVec(6, c, c == 1, c == 5, 8'h03, 64'h1, 1'b0, c == 7);

      // Reset values, with ready forced low while reset is held.
      rst = 1'b1; host_en = 1'b1; s_cmd_valid = 1'b0; s_cmd_last = 1'b0;
      s_cmd_addr = '0; s_cmd_data = '0;
      tick();
      tick();
      checkOutput("rst_ready", 64'(ready_a), 64'(0));
      checkOutput("rst_we", 64'(we_a), 64'(0));
      checkOutput("rst_en", 64'(en_a), 64'(0));
      checkOutput("rst_busy", 64'(busy_a), 64'(0));
      checkOutput("rst_done", 64'(done_a), 64'(0));
      checkOutput("rst_level", 64'(level_a), 64'(0));
      checkOutput("rst_addr", 64'(addr_a), 64'(0));
      rst = 1'b0;
      tick();
      checkOutput("idle_en_follow", 64'(en_a), 64'(1));
      checkOutput("idle_ready", 64'(ready_a), 64'(1));

      $display("[TB] test 1: single-entry batch");
      doReset();
      applyStimulus(8'h03, 64'h1, 1'b1);
      runTable(1, 1'b0);

      $display("[TB] test 2: three-entry batch");
      doReset();
      applyStimulus(8'h10, 64'hC0DE_0000_0000_0010, 1'b0);
      applyStimulus(8'h11, 64'hC0DE_0000_0000_0011, 1'b0);
      applyStimulus(8'h12, 64'hC0DE_0000_0000_0012, 1'b1);
      runTable(2, 1'b0);

      $display("[TB] test 3: batch larger than the FIFO");
      doReset();
      for (int i = 0; i < 8; i++)
         applyStimulus(8'h20 + 8'(i), 64'(i), 1'b0);
      checkOutput("t3_full_ready", 64'(ready_a), 64'(0));
      checkOutput("t3_full_level", 64'(level_a), 64'(8));
      checkOutput("t3_full_idle", 64'(busy_a), 64'(0));
      tick();
      checkOutput("t3_start_busy", 64'(busy_a), 64'(1));
      checkOutput("t3_start_en", 64'(en_a), 64'(0));
      applyStimulus(8'h28, 64'h8, 1'b0);
      k = 0;
      while (!(wr_log.size() == 9 && !we_a) && k < 200) begin
         tick();
         k++;
      end
      if (k >= 200) failTimeout("t3_ninth_write");
      tick(); tick(); tick();
      checkOutput("t3_gap_busy", 64'(busy_a), 64'(1));
      checkOutput("t3_gap_en", 64'(en_a), 64'(0));
      checkOutput("t3_gap_we", 64'(we_a), 64'(0));
      checkOutput("t3_gap_level", 64'(level_a), 64'(0));
      checkOutput("t3_gap_writes", 64'(wr_log.size()), 64'(9));
      applyStimulus(8'h29, 64'h9, 1'b1);
      k = 0;
      while (!done_a && k < 50) begin
         tick();
         k++;
      end
      if (!done_a) failTimeout("t3_batch_done");
      checkOutput("t3_total_writes", 64'(wr_log.size()), 64'(10));
      for (int i = 0; i < 10 && i < wr_log.size(); i++)
         checkOutput($sformatf("t3_order_%0d", i), 64'(wr_log[i]), 64'(8'h20 + 8'(i)));
      tick();
      checkOutput("t3_en_back", 64'(en_a), 64'(1));

      $display("[TB] test 4: no pause (dut_b)");
      doReset();
      applyStimulus(8'h03, 64'h1, 1'b1);
      runTable(4, 1'b1);

      $display("[TB] test 5: reset during the second write");
      doReset();
      applyStimulus(8'h30, 64'h30, 1'b0);
      applyStimulus(8'h31, 64'h31, 1'b0);
      applyStimulus(8'h32, 64'h32, 1'b1);
      k = 0;
      while (!(we_a && addr_a == 8'h31) && k < 50) begin
         tick();
         k++;
      end
      if (k >= 50) failTimeout("t5_second_write");
      rst = 1'b1;
      #1;
      checkOutput("t5_rst_we", 64'(we_a), 64'(0));
      checkOutput("t5_rst_level", 64'(level_a), 64'(0));
      checkOutput("t5_rst_ready", 64'(ready_a), 64'(0));
      checkOutput("t5_rst_busy", 64'(busy_a), 64'(0));
      checkOutput("t5_log_before", 64'(wr_log.size()), 64'(1));
      tick();
      tick();
      rst = 1'b0;
      tick();
      checkOutput("t5_en_after", 64'(en_a), 64'(1));
      for (int i = 0; i < 15; i++) tick();
      checkOutput("t5_no_pulse", 64'(wr_log.size()), 64'(1));
      checkOutput("t5_idle", 64'(busy_a), 64'(0));

      $display("[TB] test 6: host_en drops during quiesce");
      doReset();
      applyStimulus(8'h03, 64'h1, 1'b1);
      runTable(6, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
